// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester, multiplier and response bus of mult_share_arbiter
interface mult_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_p;
    logic               resp_valid;
    logic               resp_id;
    logic [2*WIDTH-1:0] resp_prod;
    logic               resp_ready;
    logic               busy;

    // Arbiter side: owns the ready, multiplier-operand and response signals.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_p, resp_ready,
        output req0_ready, req1_ready,
        output mul_a, mul_b,
        output resp_valid, resp_id, resp_prod, busy
    );

    // Requester, multiplier and consumer side.
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_p, resp_ready,
        input  req0_ready, req1_ready,
        input  mul_a, mul_b,
        input  resp_valid, resp_id, resp_prod, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one array multiplier; MULT_ARB_CNT_EN adds done counters
module mult_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arbiter_if.slave bus
`ifdef MULT_ARB_CNT_EN
    ,
    output logic [7:0]          done_cnt0,
    output logic [7:0]          done_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               last_grant;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic               resp_valid_r;
    logic               resp_id_r;
    logic [2*WIDTH-1:0] resp_prod_r;

    logic               gnt_any;
    logic               gnt_id;
    logic               gnt_go;
    logic [WIDTH-1:0]   gnt_a;
    logic [WIDTH-1:0]   gnt_b;
    logic               resp_fire;

    // Pick the winner: a lone request wins, a tie goes to whoever did not win last.
    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        gnt_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = bus.req1_valid;
        end
        gnt_a   = gnt_id ? bus.req1_a : bus.req0_a;
        gnt_b   = gnt_id ? bus.req1_b : bus.req0_b;
        gnt_go  = (state == IDLE) && gnt_any;
    end

    assign bus.req0_ready = gnt_go & ~gnt_id;
    assign bus.req1_ready = gnt_go & gnt_id;
    assign resp_fire      = resp_valid_r & bus.resp_ready;

    assign bus.mul_a      = mul_a_r;
    assign bus.mul_b      = mul_b_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_prod  = resp_prod_r;
    assign bus.busy       = (state != IDLE);

    // Grant -> one settle cycle for the multiplier -> hold response until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            mul_a_r      <= '0;
            mul_b_r      <= '0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_prod_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        mul_a_r    <= gnt_a;
                        mul_b_r    <= gnt_b;
                        resp_id_r  <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    resp_prod_r  <= bus.mul_p;
                    resp_valid_r <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_fire) begin
                        resp_valid_r <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MULT_ARB_CNT_EN
    // Count accepted responses per requester, sticking at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt0 <= 8'd0;
            done_cnt1 <= 8'd0;
        end else if (resp_fire) begin
            if (!resp_id_r && done_cnt0 != 8'hFF) begin
                done_cnt0 <= done_cnt0 + 8'd1;
            end
            if (resp_id_r && done_cnt1 != 8'hFF) begin
                done_cnt1 <= done_cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule
